// File: rtl/fifo_stream_reader_if.sv
// Stream reader bundle: show-ahead FIFO read port plus the outgoing valid/ready stream.
// master = reader (pops the FIFO, drives the stream); slave = FIFO/downstream side.
interface fifo_stream_reader_if #(
    parameter int DATAW = 32
);
    logic [DATAW-1:0] i_fifo_rdata;
    logic             i_fifo_empty;
    logic             o_fifo_rd;
    logic             o_valid;
    logic             i_ready;
    logic [DATAW-1:0] o_data;
    logic             o_last;

    modport master (
        input  i_fifo_rdata, i_fifo_empty, i_ready,
        output o_fifo_rd, o_valid, o_data, o_last
    );

    modport slave (
        output i_fifo_rdata, i_fifo_empty, i_ready,
        input  o_fifo_rd, o_valid, o_data, o_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Async-FIFO read-side consumer: 2-entry skid buffer into a registered valid/ready stream with burst framing.
// Define FIFO_STREAM_READER_STATS_EN to add the o_word_cnt / o_starve_cnt statistics outputs.
module fifo_stream_reader #(
    parameter int DATAW     = 32,
    parameter int BURST_LEN = 16,
    parameter int CNTW      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_flush,
    fifo_stream_reader_if.master  bus,
    output logic                  o_busy,
    output logic [1:0]            o_dbg_state
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output logic [CNTW-1:0]       o_word_cnt,
    output logic [CNTW-1:0]       o_starve_cnt
`endif
);
    // Handshake: a word moves downstream on every edge where o_valid & i_ready;
    // o_data/o_last are frozen while o_valid=1 and i_ready=0, and o_valid only
    // falls after a transfer, on i_flush, or on reset.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(BURST_LEN - 1);

    state_e           state_q;
    logic [1:0]       count_q, count_d;
    logic [DATAW-1:0] head_data_q, head_data_d;
    logic [DATAW-1:0] tail_data_q, tail_data_d;
    logic             head_last_q, head_last_d;
    logic             tail_last_q, tail_last_d;
    logic [CNTW-1:0]  burst_q, burst_d;
    logic             valid;
    logic             xfer;
    logic             pop;
    logic             pop_last;

    assign valid    = (count_q != 2'd0);
    assign xfer     = valid & bus.i_ready;
    assign pop      = i_en & ~bus.i_fifo_empty & ~i_flush & (state_q == RUN)
                    & ((count_q < 2'd2) | xfer);
    assign pop_last = (burst_q == LAST_IDX);

    assign bus.o_fifo_rd = pop;
    assign bus.o_valid   = valid;
    assign bus.o_data    = head_data_q;
    assign bus.o_last    = head_last_q;
    assign o_busy        = (state_q != IDLE);
    assign o_dbg_state   = state_q;

    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        burst_d     = burst_q;
        if (i_flush) begin
            count_d = 2'd0;
            burst_d = '0;
        end else begin
            if (pop) begin
                burst_d = pop_last ? '0 : burst_q + CNTW'(1);
            end
            case ({pop, xfer})
                2'b10: begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd0) begin
                        head_data_d = bus.i_fifo_rdata;
                        head_last_d = pop_last;
                    end else begin
                        tail_data_d = bus.i_fifo_rdata;
                        tail_last_d = pop_last;
                    end
                end
                2'b01: begin
                    count_d     = count_q - 2'd1;
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                end
                2'b11: begin
                    // Pop and transfer together: the new word lands behind whatever is still queued.
                    if (count_q == 2'd2) begin
                        head_data_d = tail_data_q;
                        head_last_d = tail_last_q;
                        tail_data_d = bus.i_fifo_rdata;
                        tail_last_d = pop_last;
                    end else begin
                        head_data_d = bus.i_fifo_rdata;
                        head_last_d = pop_last;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            count_q     <= 2'd0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
            burst_q     <= '0;
        end else begin
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
            burst_q     <= burst_d;
            if (i_flush) begin
                state_q <= i_en ? RUN : IDLE;
            end else begin
                case (state_q)
                    IDLE:    if (i_en) state_q <= RUN;
                    RUN:     if (!i_en) state_q <= (count_d == 2'd0) ? IDLE : DRAIN;
                    DRAIN: begin
                        if (i_en)                  state_q <= RUN;
                        else if (count_d == 2'd0)  state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [CNTW-1:0] word_cnt_q, starve_cnt_q;

    // Statistics survive i_flush; only reset clears them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            word_cnt_q   <= '0;
            starve_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_q + CNTW'(xfer);
            if ((state_q == RUN) && (count_q == 2'd0) && bus.i_fifo_empty && (starve_cnt_q != '1)) begin
                starve_cnt_q <= starve_cnt_q + CNTW'(1);
            end
        end
    end

    assign o_word_cnt   = word_cnt_q;
    assign o_starve_cnt = starve_cnt_q;
`endif
endmodule
